// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle sequencer.
// Opcodes, state codes and datapath select values.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_FUNC = 3'd2;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] PC_REG = 2'd3;

    localparam logic [1:0] RD_RT  = 2'd0;
    localparam logic [1:0] RD_RD  = 2'd1;
    localparam logic [1:0] RD_R31 = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    typedef struct packed {
        logic       imem_rd;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       alu_src_imm;
        logic       dmem_rd;
        logic       dmem_wr;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wb_sel;
    } ctrl_t;

endpackage

// File: rtl/mc_seq_ctrl_if.sv
// Instruction/data memory request-ready handshake bundle.
// master = sequencer side, slave = memory side.
interface mc_seq_ctrl_if;

    logic imem_rd;
    logic imem_ready;
    logic dmem_rd;
    logic dmem_wr;
    logic dmem_ready;

    modport master (
        output imem_rd,
        output dmem_rd,
        output dmem_wr,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_rd,
        input  dmem_rd,
        input  dmem_wr,
        output imem_ready,
        output dmem_ready
    );

endinterface

// File: rtl/mc_wait_timer.sv
// Memory stall watchdog: counts consecutive stalled cycles
// and raises a sticky error once the limit is reached.
module mc_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_stall,
    output logic o_mem_err
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Saturating stall counter; any non-stalled cycle restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (i_stall) begin
            if (r_cnt != CW'(WAIT_MAX))
                r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WAIT_MAX - 1))
                r_err <= 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_mem_err = r_err;

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Optional TRAP state on illegal opcode: MC_SEQ_CTRL_TRAP_EN.
module mc_seq_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    mc_seq_ctrl_if.master    bus,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             mem_err
);

    state_t           r_state;
    state_t           w_next;
    logic             r_run;
    logic [CNT_W-1:0] r_retired;
    ctrl_t            w_ctl;
    logic             w_stall;

    logic w_is_r, w_lw, w_sw, w_beq, w_addi;
    logic w_j, w_jal, w_jr, w_exec, w_ill;

    assign w_is_r = (opcode == OP_RTYPE);
    assign w_lw   = (opcode == OP_LW);
    assign w_sw   = (opcode == OP_SW);
    assign w_beq  = (opcode == OP_BEQ);
    assign w_addi = (opcode == OP_ADDI);
    assign w_j    = (opcode == OP_J);
    assign w_jal  = (opcode == OP_JAL);
    assign w_jr   = w_is_r && (funct == FN_JR);
    assign w_exec = (w_is_r && !w_jr) || w_lw || w_sw
                  || w_beq || w_addi;
    assign w_ill  = !(w_j || w_jal || w_jr || w_exec);

    // Next state and control strobes; r_run holds everything
    // quiet until the first edge after reset is released.
    always_comb begin
        w_next = r_state;
        w_ctl  = '0;
        if (r_run) begin
            unique case (r_state)
                S_FETCH: begin
                    w_ctl.imem_rd = 1'b1;
                    if (bus.imem_ready) begin
                        w_ctl.ir_we  = 1'b1;
                        w_ctl.pc_we  = 1'b1;
                        w_ctl.pc_src = PC_SEQ;
                        w_next       = S_DECODE;
                    end
                end
                S_DECODE: begin
                    unique case (1'b1)
                        w_j: begin
                            w_ctl.pc_we  = 1'b1;
                            w_ctl.pc_src = PC_JMP;
                            w_next       = S_FETCH;
                        end
                        w_jal: begin
                            w_ctl.pc_we   = 1'b1;
                            w_ctl.pc_src  = PC_JMP;
                            w_ctl.reg_we  = 1'b1;
                            w_ctl.reg_dst = RD_R31;
                            w_ctl.wb_sel  = WB_PC;
                            w_next        = S_FETCH;
                        end
                        w_jr: begin
                            w_ctl.pc_we  = 1'b1;
                            w_ctl.pc_src = PC_REG;
                            w_next       = S_FETCH;
                        end
                        w_exec: w_next = S_EXEC;
                        w_ill: begin
`ifdef MC_SEQ_CTRL_TRAP_EN
                            w_next = S_TRAP;
`else
                            w_next = S_FETCH;
`endif
                        end
                    endcase
                end
                S_EXEC: begin
                    unique case (1'b1)
                        w_is_r: begin
                            w_ctl.alu_op = ALU_FUNC;
                            w_next       = S_WB;
                        end
                        w_addi: begin
                            w_ctl.alu_op      = ALU_ADD;
                            w_ctl.alu_src_imm = 1'b1;
                            w_next            = S_WB;
                        end
                        (w_lw || w_sw): begin
                            w_ctl.alu_op      = ALU_ADD;
                            w_ctl.alu_src_imm = 1'b1;
                            w_next            = S_MEM;
                        end
                        w_beq: begin
                            w_ctl.alu_op = ALU_SUB;
                            w_ctl.pc_we  = zero;
                            w_ctl.pc_src = PC_BR;
                            w_next       = S_FETCH;
                        end
                        default: w_next = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (w_lw) begin
                        w_ctl.dmem_rd = 1'b1;
                        if (bus.dmem_ready)
                            w_next = S_WB;
                    end else if (w_sw) begin
                        w_ctl.dmem_wr = 1'b1;
                        if (bus.dmem_ready)
                            w_next = S_FETCH;
                    end else begin
                        w_next = S_FETCH;
                    end
                end
                S_WB: begin
                    w_ctl.reg_we  = 1'b1;
                    w_ctl.reg_dst = w_is_r ? RD_RD : RD_RT;
                    w_ctl.wb_sel  = w_lw ? WB_MEM : WB_ALU;
                    w_next        = S_FETCH;
                end
`ifdef MC_SEQ_CTRL_TRAP_EN
                S_TRAP: w_next = S_TRAP;
`endif
                default: w_next = S_FETCH;
            endcase
        end
    end

    // State register and retire counter; a return to FETCH
    // from any other state completes one instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FETCH;
            r_run     <= 1'b0;
            r_retired <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next;
            if (r_state != S_FETCH && w_next == S_FETCH)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign w_stall = (w_ctl.imem_rd & ~bus.imem_ready)
                   | ((w_ctl.dmem_rd | w_ctl.dmem_wr)
                      & ~bus.dmem_ready);

    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait (
        .clk       (clk),
        .reset     (reset),
        .i_stall   (w_stall),
        .o_mem_err (mem_err)
    );

    assign bus.imem_rd = w_ctl.imem_rd;
    assign bus.dmem_rd = w_ctl.dmem_rd;
    assign bus.dmem_wr = w_ctl.dmem_wr;
    assign ir_we       = w_ctl.ir_we;
    assign pc_we       = w_ctl.pc_we;
    assign pc_src      = w_ctl.pc_src;
    assign alu_op      = w_ctl.alu_op;
    assign alu_src_imm = w_ctl.alu_src_imm;
    assign reg_we      = w_ctl.reg_we;
    assign reg_dst     = w_ctl.reg_dst;
    assign wb_sel      = w_ctl.wb_sel;
    assign state       = r_state;
    assign retired     = r_retired;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed bench for mc_seq_ctrl: cycle table plus
// hand sequences for reset, stall timeout and illegal opcode.
module tb_mc_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'h20;
    logic        zero = 1'b0;
    logic        ir_we, pc_we, alu_src_imm, reg_we, mem_err;
    logic [1:0]  pc_src, reg_dst, wb_sel;
    logic [2:0]  alu_op, state;
    logic [31:0] retired;

    mc_seq_ctrl_if bus();

    mc_seq_ctrl #(.CNT_W(32), .WAIT_MAX(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_we      (reg_we),
        .reg_dst     (reg_dst),
        .wb_sel      (wb_sel),
        .state       (state),
        .retired     (retired),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ir;
        logic        dr;
        logic [18:0] e;
        logic [31:0] ret;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [18:0] o(
        input logic [2:0] st, input logic ird, input logic irw,
        input logic pcw, input logic [1:0] src,
        input logic [2:0] alu, input logic imm, input logic drd,
        input logic dwr, input logic rwe, input logic [1:0] rdst,
        input logic [1:0] wbs);
        return {st, ird, irw, pcw, src, alu, imm,
                drd, dwr, rwe, rdst, wbs};
    endfunction

    function automatic logic [51:0] snap();
        return {state, bus.imem_rd, ir_we, pc_we, pc_src, alu_op,
                alu_src_imm, bus.dmem_rd, bus.dmem_wr, reg_we,
                reg_dst, wb_sel, retired, mem_err};
    endfunction

    task automatic chk(input string nm, input logic [51:0] exp);
        logic [51:0] got;
        got = snap();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ir, input logic dr,
                       input logic [18:0] e, input int ret);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.ir = ir; v.dr = dr;
        v.e = e; v.ret = ret;
        vq.push_back(v);
    endtask

    localparam logic [18:0] FET = 19'b000_1_1_1_00_000_0_0_0_0_00_00;
    localparam logic [18:0] DEC = 19'b001_0_0_0_00_000_0_0_0_0_00_00;

    initial begin
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;

        // R add
        add(6'h00, 6'h20, 0, 1, 1, FET, 0);
        add(6'h00, 6'h20, 0, 1, 1, DEC, 0);
        add(6'h00, 6'h20, 0, 1, 1, o(2,0,0,0,0,2,0,0,0,0,0,0), 0);
        add(6'h00, 6'h20, 0, 1, 1, o(4,0,0,0,0,0,0,0,0,1,1,0), 0);
        // lw with 3-cycle data stall
        add(6'h23, 6'h00, 0, 1, 1, FET, 1);
        add(6'h23, 6'h00, 0, 1, 1, DEC, 1);
        add(6'h23, 6'h00, 0, 1, 1, o(2,0,0,0,0,0,1,0,0,0,0,0), 1);
        add(6'h23, 6'h00, 0, 1, 0, o(3,0,0,0,0,0,0,1,0,0,0,0), 1);
        add(6'h23, 6'h00, 0, 1, 0, o(3,0,0,0,0,0,0,1,0,0,0,0), 1);
        add(6'h23, 6'h00, 0, 1, 0, o(3,0,0,0,0,0,0,1,0,0,0,0), 1);
        add(6'h23, 6'h00, 0, 1, 1, o(3,0,0,0,0,0,0,1,0,0,0,0), 1);
        add(6'h23, 6'h00, 0, 1, 1, o(4,0,0,0,0,0,0,0,0,1,0,1), 1);
        // sw
        add(6'h2b, 6'h00, 0, 1, 1, FET, 2);
        add(6'h2b, 6'h00, 0, 1, 1, DEC, 2);
        add(6'h2b, 6'h00, 0, 1, 1, o(2,0,0,0,0,0,1,0,0,0,0,0), 2);
        add(6'h2b, 6'h00, 0, 1, 1, o(3,0,0,0,0,0,0,0,1,0,0,0), 2);
        // beq taken / not taken
        add(6'h04, 6'h00, 1, 1, 1, FET, 3);
        add(6'h04, 6'h00, 1, 1, 1, DEC, 3);
        add(6'h04, 6'h00, 1, 1, 1, o(2,0,0,1,1,1,0,0,0,0,0,0), 3);
        add(6'h04, 6'h00, 0, 1, 1, FET, 4);
        add(6'h04, 6'h00, 0, 1, 1, DEC, 4);
        add(6'h04, 6'h00, 0, 1, 1, o(2,0,0,0,1,1,0,0,0,0,0,0), 4);
        // addi
        add(6'h08, 6'h00, 0, 1, 1, FET, 5);
        add(6'h08, 6'h00, 0, 1, 1, DEC, 5);
        add(6'h08, 6'h00, 0, 1, 1, o(2,0,0,0,0,0,1,0,0,0,0,0), 5);
        add(6'h08, 6'h00, 0, 1, 1, o(4,0,0,0,0,0,0,0,0,1,0,0), 5);
        // jal, j, jr
        add(6'h03, 6'h00, 0, 1, 1, FET, 6);
        add(6'h03, 6'h00, 0, 1, 1, o(1,0,0,1,2,0,0,0,0,1,2,2), 6);
        add(6'h02, 6'h00, 0, 1, 1, FET, 7);
        add(6'h02, 6'h00, 0, 1, 1, o(1,0,0,1,2,0,0,0,0,0,0,0), 7);
        add(6'h00, 6'h08, 0, 1, 1, FET, 8);
        add(6'h00, 6'h08, 0, 1, 1, o(1,0,0,1,3,0,0,0,0,0,0,0), 8);

        // Reach EXEC of an R-type, then reset mid-instruction.
        #12 reset = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        chk("pre_reset_exec", {o(2,0,0,0,0,2,0,0,0,0,0,0), 32'd0, 1'b0});
        #2 reset = 1'b0;
        #1 chk("reset_mid_exec", {19'd0, 32'd0, 1'b0});
        @(negedge clk);
        reset = 1'b1;
        #1 chk("released_pre_edge", {19'd0, 32'd0, 1'b0});

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            opcode = vq[i].op;
            funct  = vq[i].fn;
            zero   = vq[i].z;
            bus.imem_ready = vq[i].ir;
            bus.dmem_ready = vq[i].dr;
            #1 chk($sformatf("row%0d", i), {vq[i].e, vq[i].ret, 1'b0});
        end

        // Instruction fetch stall past the timeout limit.
        opcode = 6'h3f;
        funct  = 6'h00;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            bus.imem_ready = 1'b0;
            #1 chk($sformatf("stall%0d", k),
                   {o(0,1,0,0,0,0,0,0,0,0,0,0), 32'd9, k >= 16});
        end
        @(negedge clk);
        bus.imem_ready = 1'b1;
        #1 chk("stall_release", {FET, 32'd9, 1'b1});
        @(negedge clk);
        #1 chk("illegal_decode", {DEC, 32'd9, 1'b1});
        @(negedge clk);
`ifdef MC_SEQ_CTRL_TRAP_EN
        #1 chk("trap_enter", {o(5,0,0,0,0,0,0,0,0,0,0,0), 32'd9, 1'b1});
        @(negedge clk);
        #1 chk("trap_hold", {o(5,0,0,0,0,0,0,0,0,0,0,0), 32'd9, 1'b1});
`else
        #1 chk("illegal_nop", {FET, 32'd10, 1'b1});
        @(negedge clk);
        #1 chk("after_nop", {DEC, 32'd10, 1'b1});
`endif

        #1 reset = 1'b0;
        #1 chk("final_reset", {19'd0, 32'd0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
